// File: rtl/ps2_defs.sv
// Shared constants and state encoding for the PS/2 mouse initialization sequencer.
// The command table maps a step index to the byte the host must send.
package ps2_defs;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_SET_RES  = 8'hE8;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERR      = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ID_STD   = 8'h00;

  localparam logic [2:0] STEP_LAST  = 3'd5;
  localparam logic [1:0] MAX_RESEND = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_DONE,
    ST_FAIL
  } state_e;

  // Steps 2 and 4 carry the argument bytes of the preceding command.
  function automatic logic [7:0] step_byte(input logic [2:0] step,
                                           input logic [7:0] rate,
                                           input logic [7:0] res);
    logic [7:0] b;
    case (step)
      3'd0:    b = CMD_RESET;
      3'd1:    b = CMD_SET_RATE;
      3'd2:    b = rate;
      3'd3:    b = CMD_SET_RES;
      3'd4:    b = res;
      3'd5:    b = CMD_ENABLE;
      default: b = CMD_RESET;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse init sequencer: sends reset/rate/resolution/enable, checks ACK/BAT/ID,
// resends on NAK, times out waits, and restarts the whole sequence a bounded number of times.
module ps2_mouse_init_seq
  import ps2_defs::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd3_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [7:0]  SAMPLE_RATE    = 8'd100,
  parameter logic [7:0]  RESOLUTION     = 8'h02
) (
  input  logic       clk_30,
  input  logic       reset_n,
  input  logic       start,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic       busy,
  output logic       stream_enable,
  output logic       init_fail,
  output logic [1:0] retry_count
);

  localparam logic [1:0] MaxRetryC = 2'(MAX_RETRY);

  state_e      state_q;
  logic [2:0]  step_q;
  logic [1:0]  resend_q;
  logic [1:0]  retry_q;
  logic [26:0] timer_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        busy_q;
  logic        stream_en_q;
  logic        init_fail_q;

  logic [7:0]  tx_byte_d;
  logic [26:0] limit_d;
  logic        timeout_d;
  logic        resend_req_d;
  logic        fail_d;

  assign tx_byte_d    = step_byte(step_q, SAMPLE_RATE, RESOLUTION);
  // The BAT self-test is slow, so its wait gets eight times the normal budget.
  assign limit_d      = (state_q == ST_WAIT_BAT) ? {TIMEOUT_CYCLES, 3'b000}
                                                 : {3'b000, TIMEOUT_CYCLES};
  assign timeout_d    = (timer_q == limit_d);
  assign resend_req_d = rx_error || (rx_valid && (rx_data == RSP_RESEND));

  always_comb begin
    fail_d = 1'b0;
    case (state_q)
      ST_WAIT_ACK: begin
        if (resend_req_d)  fail_d = (resend_q == MAX_RESEND);
        else if (rx_valid) fail_d = (rx_data != RSP_ACK);
        else               fail_d = timeout_d;
      end
      ST_WAIT_BAT: begin
        if (rx_valid || rx_error) fail_d = rx_error || (rx_data != RSP_BAT_OK);
        else                      fail_d = timeout_d;
      end
      ST_WAIT_ID: begin
        if (rx_valid || rx_error) fail_d = rx_error || (rx_data != RSP_ID_STD);
        else                      fail_d = timeout_d;
      end
      default: fail_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_30 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      step_q      <= 3'd0;
      resend_q    <= 2'd0;
      retry_q     <= 2'd0;
      timer_q     <= 27'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      stream_en_q <= 1'b0;
      init_fail_q <= 1'b0;
    end else if (start) begin
      state_q     <= ST_SEND;
      step_q      <= 3'd0;
      resend_q    <= 2'd0;
      retry_q     <= 2'd0;
      timer_q     <= 27'd0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b1;
      stream_en_q <= 1'b0;
      init_fail_q <= 1'b0;
    end else if (fail_d) begin
      step_q   <= 3'd0;
      resend_q <= 2'd0;
      timer_q  <= 27'd0;
      if (retry_q == MaxRetryC) begin
        state_q     <= ST_FAIL;
        busy_q      <= 1'b0;
        init_fail_q <= 1'b1;
      end else begin
        state_q <= ST_SEND;
        retry_q <= retry_q + 2'd1;
      end
    end else begin
      case (state_q)
        ST_SEND: begin
          if (tx_valid_q && tx_ready) begin
            tx_valid_q <= 1'b0;
            timer_q    <= 27'd0;
            state_q    <= ST_WAIT_ACK;
          end else begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= tx_byte_d;
          end
        end
        ST_WAIT_ACK: begin
          timer_q <= timer_q + 27'd1;
          if (resend_req_d) begin
            resend_q <= resend_q + 2'd1;
            timer_q  <= 27'd0;
            state_q  <= ST_SEND;
          end else if (rx_valid) begin
            resend_q <= 2'd0;
            timer_q  <= 27'd0;
            if (step_q == 3'd0) begin
              state_q <= ST_WAIT_BAT;
            end else if (step_q == STEP_LAST) begin
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              stream_en_q <= 1'b1;
            end else begin
              step_q  <= step_q + 3'd1;
              state_q <= ST_SEND;
            end
          end
        end
        ST_WAIT_BAT: begin
          timer_q <= timer_q + 27'd1;
          if (rx_valid || rx_error) begin
            timer_q <= 27'd0;
            state_q <= ST_WAIT_ID;
          end
        end
        ST_WAIT_ID: begin
          timer_q <= timer_q + 27'd1;
          // The reset command is done once the ID arrives; continue with the rate command.
          if (rx_valid || rx_error) begin
            timer_q <= 27'd0;
            step_q  <= 3'd1;
            state_q <= ST_SEND;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign busy          = busy_q;
  assign stream_enable = stream_en_q;
  assign init_fail     = init_fail_q;
  assign retry_count   = retry_q;

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Bench for ps2_mouse_init_seq: directed scenarios plus randomized mouse replies
// checked against an abstract model of the init protocol.
module tb_ps2_mouse_init_seq;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset_n, start, tx_ready, rx_valid, rx_error;
  logic [7:0] rx_data;
  logic       tx_valid, busy, stream_enable, init_fail;
  logic [7:0] tx_data;
  logic [1:0] retry_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_log[$];
  logic [7:0] exp_q[$];
  logic [7:0] cmds     [6] = '{8'hFF, 8'hF3, 8'd100, 8'hE8, 8'h02, 8'hF4};
  logic [7:0] junk_ack [5] = '{8'h00, 8'hAA, 8'hFC, 8'h55, 8'hF4};
  logic [7:0] bad_bat  [3] = '{8'hFC, 8'h00, 8'hFA};
  logic [7:0] bad_id   [3] = '{8'hAA, 8'h03, 8'hFA};

  // Abstract protocol model: command index, NAKs on current byte, restarts, phase, outcome.
  int m_idx, m_naks, m_retry, m_phase, m_out;

  always #5 clk = ~clk;

  ps2_mouse_init_seq #(
    .TIMEOUT_CYCLES(24'd100),
    .MAX_RETRY     (3),
    .SAMPLE_RATE   (8'd100),
    .RESOLUTION    (8'h02)
  ) dut (
    .clk_30       (clk),
    .reset_n      (reset_n),
    .start        (start),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_error     (rx_error),
    .busy         (busy),
    .stream_enable(stream_enable),
    .init_fail    (init_fail),
    .retry_count  (retry_count)
  );

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time exhausted, tests=%0d", n_tests);
    $fatal(1);
  end

  function automatic string log_str(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
    return s;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Accept one command byte with random back-pressure; b is X if none arrives.
  task automatic get_tx(output logic [7:0] b, output bit ok);
    bit hs;
    b  = 'x;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      hs = 1'b0;
      tx_ready = ($urandom_range(0, 2) != 0);
      if (tx_valid && tx_ready) begin
        b  = tx_data;
        hs = 1'b1;
      end
      @(posedge clk); #1;
      tx_ready = 1'b0;
      if (hs) begin
        ok = 1'b1;
        tx_log.push_back(b);
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit v, input bit e, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    rx_valid = v;
    rx_error = e;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Well-behaved mouse from command index s0 through the enable command.
  task automatic ack_from(input int s0);
    logic [7:0] b;
    bit ok;
    for (int s = s0; s < 6; s++) begin
      get_tx(b, ok);
      send_rx(8'hFA, 1'b1, 1'b0, $urandom_range(0, 3));
      if (s == 0) begin
        send_rx(8'hAA, 1'b1, 1'b0, $urandom_range(0, 3));
        send_rx(8'h00, 1'b1, 1'b0, $urandom_range(0, 3));
      end
    end
  endtask

  task automatic model_fail();
    m_naks  = 0;
    m_idx   = 0;
    m_phase = 0;
    if (m_retry == 3) m_out = 2;
    else m_retry++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({tx_valid, tx_data} !== 9'h000) begin
      n_fail++; $display("FAIL reset_tx: got valid=%b data=%h, want 0/00", tx_valid, tx_data);
    end
    n_tests++;
    if ({busy, stream_enable, init_fail, retry_count} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got busy=%b se=%b fail=%b retry=%0d, want all 0",
                         busy, stream_enable, init_fail, retry_count);
    end
    reset_n = 1'b1;
    send_rx(8'hFA, 1'b1, 1'b0, 1);
    send_rx(8'hFE, 1'b1, 1'b1, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if ({tx_valid, busy, stream_enable, init_fail} !== 4'b0) begin
      n_fail++; $display("FAIL idle_rx_ignored: got txv=%b busy=%b se=%b fail=%b, want 0",
                         tx_valid, busy, stream_enable, init_fail);
    end
  endtask

  task automatic test_nominal();
    tx_log.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if ({tx_valid, busy} !== 2'b01) begin
      n_fail++; $display("FAIL send_entry: got txv=%b busy=%b, want txv=0 busy=1", tx_valid, busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({tx_valid, tx_data} !== 9'h1FF) begin
      n_fail++; $display("FAIL send_rise: got txv=%b data=%h, want 1/ff", tx_valid, tx_data);
    end
    ack_from(0);
    n_tests++;
    if ({stream_enable, busy, init_fail, retry_count} !== 5'b10000) begin
      n_fail++; $display("FAIL nominal_done: got se=%b busy=%b fail=%b retry=%0d, want 1 0 0 0",
                         stream_enable, busy, init_fail, retry_count);
    end
    exp_q = '{8'hFF, 8'hF3, 8'h64, 8'hE8, 8'h02, 8'hF4};
    n_tests++;
    if (log_str(tx_log) != log_str(exp_q)) begin
      n_fail++; $display("FAIL nominal_bytes: got %s want %s", log_str(tx_log), log_str(exp_q));
    end
    send_rx(8'hFE, 1'b1, 1'b0, 2);
    n_tests++;
    if ({stream_enable, tx_valid} !== 2'b10) begin
      n_fail++; $display("FAIL done_rx_ignored: got se=%b txv=%b, want 1 0", stream_enable, tx_valid);
    end
  endtask

  task automatic test_nak();
    logic [7:0] b;
    bit ok;
    tx_log.delete();
    pulse_start();
    get_tx(b, ok);
    send_rx(8'hFA, 1'b1, 1'b0, 1);
    send_rx(8'hAA, 1'b1, 1'b0, 1);
    send_rx(8'h00, 1'b1, 1'b0, 1);
    get_tx(b, ok);
    send_rx(8'hFE, 1'b1, 1'b0, 2);
    ack_from(1);
    exp_q = '{8'hFF, 8'hF3, 8'hF3, 8'h64, 8'hE8, 8'h02, 8'hF4};
    n_tests++;
    if (log_str(tx_log) != log_str(exp_q)) begin
      n_fail++; $display("FAIL nak_bytes: got %s want %s", log_str(tx_log), log_str(exp_q));
    end
    n_tests++;
    if ({stream_enable, retry_count} !== 3'b100) begin
      n_fail++; $display("FAIL nak_done: got se=%b retry=%0d, want 1 0", stream_enable, retry_count);
    end
    // Three NAKs on one byte exhaust its resends and restart the sequence.
    tx_log.delete();
    pulse_start();
    get_tx(b, ok);
    send_rx(8'hFA, 1'b1, 1'b0, 0);
    send_rx(8'hAA, 1'b1, 1'b0, 0);
    send_rx(8'h00, 1'b1, 1'b0, 0);
    get_tx(b, ok);
    send_rx(8'hFA, 1'b1, 1'b0, 0);
    get_tx(b, ok);
    send_rx(8'hFA, 1'b1, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      get_tx(b, ok);
      send_rx(8'hFE, 1'b1, 1'b0, 1);
    end
    n_tests++;
    if (retry_count !== 2'd1) begin
      n_fail++; $display("FAIL nak_limit_retry: got %0d want 1", retry_count);
    end
    ack_from(0);
    exp_q = '{8'hFF, 8'hF3, 8'h64, 8'hE8, 8'hE8, 8'hE8,
              8'hFF, 8'hF3, 8'h64, 8'hE8, 8'h02, 8'hF4};
    n_tests++;
    if (log_str(tx_log) != log_str(exp_q)) begin
      n_fail++; $display("FAIL nak_limit_bytes: got %s want %s", log_str(tx_log), log_str(exp_q));
    end
    n_tests++;
    if ({stream_enable, retry_count} !== 3'b101) begin
      n_fail++; $display("FAIL nak_limit_done: got se=%b retry=%0d, want 1 1", stream_enable, retry_count);
    end
  endtask

  task automatic test_bad_bat();
    logic [7:0] b;
    bit ok;
    tx_log.delete();
    pulse_start();
    get_tx(b, ok);
    send_rx(8'hFA, 1'b1, 1'b0, 1);
    send_rx(8'hFC, 1'b1, 1'b0, 3);
    n_tests++;
    if ({retry_count, busy} !== 3'b011) begin
      n_fail++; $display("FAIL bat_retry: got retry=%0d busy=%b, want 1 1", retry_count, busy);
    end
    ack_from(0);
    exp_q = '{8'hFF, 8'hFF, 8'hF3, 8'h64, 8'hE8, 8'h02, 8'hF4};
    n_tests++;
    if (log_str(tx_log) != log_str(exp_q)) begin
      n_fail++; $display("FAIL bat_bytes: got %s want %s", log_str(tx_log), log_str(exp_q));
    end
    n_tests++;
    if ({stream_enable, retry_count} !== 3'b101) begin
      n_fail++; $display("FAIL bat_done: got se=%b retry=%0d, want 1 1", stream_enable, retry_count);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    bit ok;
    int cnt;
    tx_log.delete();
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      get_tx(b, ok);
      n_tests++;
      if (retry_count !== 2'(k)) begin
        n_fail++; $display("FAIL timeout_retry%0d: got %0d want %0d", k, retry_count, k);
      end
    end
    cnt = 0;
    while (!init_fail && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_tests++;
    if (cnt < TO || cnt > TO + 2) begin
      n_fail++; $display("FAIL timeout_latency: got %0d cycles, want %0d..%0d", cnt, TO, TO + 2);
    end
    n_tests++;
    if ({init_fail, busy, tx_valid, retry_count} !== 5'b10011) begin
      n_fail++; $display("FAIL timeout_fail: got fail=%b busy=%b txv=%b retry=%0d, want 1 0 0 3",
                         init_fail, busy, tx_valid, retry_count);
    end
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    n_tests++;
    if (log_str(tx_log) != log_str(exp_q)) begin
      n_fail++; $display("FAIL timeout_bytes: got %s want %s", log_str(tx_log), log_str(exp_q));
    end
    send_rx(8'hFA, 1'b1, 1'b0, 2);
    repeat (10) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if ({init_fail, stream_enable, tx_valid} !== 3'b100) begin
      n_fail++; $display("FAIL fail_sticky: got fail=%b se=%b txv=%b, want 1 0 0",
                         init_fail, stream_enable, tx_valid);
    end
  endtask

  task automatic test_tx_stall();
    logic [7:0] b;
    bit ok;
    int bad;
    pulse_start();
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if ({tx_valid, tx_data} !== 9'h1FF) bad++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL stall_hold: got %0d unstable cycles, want 0 (txv=%b data=%h)",
                         bad, tx_valid, tx_data);
    end
    tx_log.delete();
    get_tx(b, ok);
    n_tests++;
    if ({tx_valid, b} !== 9'h0FF) begin
      n_fail++; $display("FAIL stall_handshake: got txv=%b byte=%h, want 0/ff", tx_valid, b);
    end
    send_rx(8'hFA, 1'b1, 1'b0, TO - 10);
    n_tests++;
    if ({retry_count, busy} !== 3'b001) begin
      n_fail++; $display("FAIL stall_ack: got retry=%0d busy=%b, want 0 1", retry_count, busy);
    end
    send_rx(8'hAA, 1'b1, 1'b0, 1);
    send_rx(8'h00, 1'b1, 1'b0, 1);
    ack_from(1);
    n_tests++;
    if ({stream_enable, retry_count} !== 3'b100) begin
      n_fail++; $display("FAIL stall_done: got se=%b retry=%0d, want 1 0", stream_enable, retry_count);
    end
  endtask

  task automatic test_restart();
    logic [7:0] b;
    bit ok;
    pulse_start();
    get_tx(b, ok);
    send_rx(8'hFA, 1'b1, 1'b0, 1);
    send_rx(8'h33, 1'b1, 1'b0, 1);
    get_tx(b, ok);
    send_rx(8'hFA, 1'b1, 1'b0, 1);
    send_rx(8'hAA, 1'b1, 1'b0, 1);
    n_tests++;
    if (retry_count !== 2'd1) begin
      n_fail++; $display("FAIL restart_pre: got retry=%0d want 1", retry_count);
    end
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(posedge clk); #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    n_tests++;
    if ({retry_count, busy, tx_valid} !== 4'b0010) begin
      n_fail++; $display("FAIL restart_state: got retry=%0d busy=%b txv=%b, want 0 1 0",
                         retry_count, busy, tx_valid);
    end
    tx_log.delete();
    get_tx(b, ok);
    n_tests++;
    if (b !== 8'hFF) begin
      n_fail++; $display("FAIL restart_byte: got %h want ff", b);
    end
    send_rx(8'hFA, 1'b1, 1'b0, 1);
    send_rx(8'hAA, 1'b1, 1'b0, 1);
    send_rx(8'h00, 1'b1, 1'b0, 1);
    ack_from(1);
    n_tests++;
    if ({stream_enable, retry_count} !== 3'b100) begin
      n_fail++; $display("FAIL restart_done: got se=%b retry=%0d, want 1 0", stream_enable, retry_count);
    end
    pulse_start();
    n_tests++;
    if ({stream_enable, busy} !== 2'b01) begin
      n_fail++; $display("FAIL restart_from_done: got se=%b busy=%b, want 0 1", stream_enable, busy);
    end
  endtask

  task automatic test_reset_midhandshake();
    pulse_start();
    @(posedge clk); #1;
    tx_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({tx_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL async_reset: got txv=%b busy=%b, want 0 0", tx_valid, busy);
    end
    tx_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if ({tx_valid, busy, retry_count} !== 4'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got txv=%b busy=%b retry=%0d, want 0",
                         tx_valid, busy, retry_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit ok, aborted;
    int r, gap, mism;
    for (int t = 0; t < 25; t++) begin
      tx_log.delete();
      exp_q.delete();
      pulse_start();
      m_idx = 0; m_naks = 0; m_retry = 0; m_phase = 0; m_out = 0;
      aborted = 1'b0;
      for (int it = 0; it < 300 && m_out == 0 && !aborted; it++) begin
        r   = $urandom_range(0, 99);
        gap = $urandom_range(0, 4);
        if (m_phase == 0) begin
          exp_q.push_back(cmds[m_idx]);
          get_tx(b, ok);
          if (!ok) aborted = 1'b1;
          else if (r < 65) begin
            send_rx(8'hFA, 1'b1, 1'b0, gap);
            m_naks = 0;
            if (m_idx == 0) m_phase = 1;
            else if (m_idx == 5) m_out = 1;
            else m_idx++;
          end else if (r < 92) begin
            if (r < 80)      send_rx(8'hFE, 1'b1, 1'b0, gap);
            else if (r < 87) send_rx(8'($urandom), 1'b0, 1'b1, gap);
            else             send_rx(8'hFA, 1'b1, 1'b1, gap);
            if (m_naks == 2) model_fail();
            else m_naks++;
          end else begin
            send_rx(junk_ack[$urandom_range(0, 4)], 1'b1, 1'b0, gap);
            model_fail();
          end
        end else if (m_phase == 1) begin
          if (r < 80) begin
            send_rx(8'hAA, 1'b1, 1'b0, gap);
            m_phase = 2;
          end else begin
            send_rx(bad_bat[$urandom_range(0, 2)], 1'b1, 1'b0, gap);
            model_fail();
          end
        end else begin
          if (r < 85) begin
            send_rx(8'h00, 1'b1, 1'b0, gap);
            m_phase = 0;
            m_idx   = 1;
          end else begin
            send_rx(bad_id[$urandom_range(0, 2)], 1'b1, 1'b0, gap);
            model_fail();
          end
        end
        if (!aborted) begin
          n_tests++;
          if (retry_count !== 2'(m_retry)) begin
            n_fail++; $display("FAIL rand_retry t%0d it%0d: got %0d want %0d", t, it, retry_count, m_retry);
          end
        end
      end
      n_tests++;
      if (aborted || m_out == 0) begin
        n_fail++; $display("FAIL rand_progress t%0d: got no handshake/outcome, want completion", t);
      end
      n_tests++;
      if ({stream_enable, init_fail, busy} !== {m_out == 1, m_out == 2, 1'b0}) begin
        n_fail++; $display("FAIL rand_outcome t%0d: got se=%b fail=%b busy=%b, want se=%b fail=%b busy=0",
                           t, stream_enable, init_fail, busy, m_out == 1, m_out == 2);
      end
      mism = -1;
      for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
        if (mism < 0 && tx_log[i] !== exp_q[i]) mism = i;
      if (mism < 0 && tx_log.size() != exp_q.size()) mism = (tx_log.size() < exp_q.size()) ? tx_log.size() : exp_q.size();
      n_tests++;
      if (mism >= 0) begin
        n_fail++;
        $display("FAIL rand_bytes t%0d: got len %0d byte %h at %0d, want len %0d byte %h",
                 t, tx_log.size(), (mism < tx_log.size()) ? tx_log[mism] : 8'hxx, mism,
                 exp_q.size(), (mism < exp_q.size()) ? exp_q[mism] : 8'hxx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_nak();
    test_bad_bat();
    test_timeout();
    test_tx_stall();
    test_restart();
    test_reset_midhandshake();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
